// File: rtl/inst_fetcher_if.sv
// Fetch-stage bundle: decoder/ROB control in, icache request/response, decoder presentation out.
// The master side is the fetcher; the slave side is its environment (icache, decoder, ROB).
interface inst_fetcher_if;
  logic        wrong_predicted;
  logic [31:0] correct_pc;
  logic        issue_signal;
  logic [31:0] next_pc;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_inst;
  logic        start_decode;
  logic [31:0] inst;
  logic [31:0] inst_addr;

  modport master (
    input  wrong_predicted, correct_pc, issue_signal, next_pc, ic_resp_valid, ic_resp_inst,
    output ic_req_valid, ic_req_addr, start_decode, inst, inst_addr
  );

  modport slave (
    output wrong_predicted, correct_pc, issue_signal, next_pc, ic_resp_valid, ic_resp_inst,
    input  ic_req_valid, ic_req_addr, start_decode, inst, inst_addr
  );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: one outstanding icache request, holds the fetched word until the
// decoder issues, and redirects on misprediction while discarding any stale in-flight response.
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  inst_fetcher_if.master  fif
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DECODE  = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_redirect_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_addr;
  logic [31:0] r_req_addr;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_redirect_nxt;
  logic [31:0] w_inst_nxt;
  logic [31:0] w_inst_addr_nxt;
  logic [31:0] w_req_addr_nxt;
  logic        w_req_valid;
  logic        w_start_decode;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_redirect_pc <= 32'h0;
      r_inst        <= 32'h0;
      r_inst_addr   <= 32'h0;
      r_req_addr    <= 32'h0;
    end else if (rdy_in) begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_redirect_pc <= w_redirect_nxt;
      r_inst        <= w_inst_nxt;
      r_inst_addr   <= w_inst_addr_nxt;
      r_req_addr    <= w_req_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_redirect_nxt  = r_redirect_pc;
    w_inst_nxt      = r_inst;
    w_inst_addr_nxt = r_inst_addr;
    w_req_addr_nxt  = r_req_addr;
    w_req_valid     = 1'b0;
    w_start_decode  = 1'b0;

    unique case (r_state)
      S_FETCH: begin
        // A redirect arriving in the bubble cycle steers this very request.
        if (fif.wrong_predicted) begin
          w_pc_nxt       = fif.correct_pc;
          w_req_addr_nxt = fif.correct_pc;
        end else begin
          w_req_addr_nxt = r_pc;
        end
        w_state_nxt = S_WAIT;
      end

      S_WAIT: begin
        w_req_valid = 1'b1;
        if (fif.ic_resp_valid && !fif.wrong_predicted) begin
          w_inst_nxt      = fif.ic_resp_inst;
          w_inst_addr_nxt = r_req_addr;
          w_state_nxt     = S_DECODE;
        end else if (fif.ic_resp_valid) begin
          w_pc_nxt    = fif.correct_pc;
          w_state_nxt = S_FETCH;
        end else if (fif.wrong_predicted) begin
          w_redirect_nxt = fif.correct_pc;
          w_state_nxt    = S_DISCARD;
        end
      end

      S_DISCARD: begin
        // Request stays up until the icache answers; the latest redirect target wins.
        w_req_valid = 1'b1;
        if (fif.ic_resp_valid) begin
          w_pc_nxt    = fif.wrong_predicted ? fif.correct_pc : r_redirect_pc;
          w_state_nxt = S_FETCH;
        end else if (fif.wrong_predicted) begin
          w_redirect_nxt = fif.correct_pc;
        end
      end

      S_DECODE: begin
        w_start_decode = 1'b1;
        if (fif.wrong_predicted) begin
          w_pc_nxt    = fif.correct_pc;
          w_state_nxt = S_FETCH;
        end else if (fif.issue_signal) begin
          w_pc_nxt    = fif.next_pc;
          w_state_nxt = S_FETCH;
        end
      end

      default: w_state_nxt = S_FETCH;
    endcase
  end

  assign fif.ic_req_valid = w_req_valid;
  assign fif.ic_req_addr  = r_req_addr;
  assign fif.start_decode = w_start_decode;
  assign fif.inst         = r_inst;
  assign fif.inst_addr    = r_inst_addr;

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: directed scenarios followed by randomized traffic, every cycle
// compared against a transaction-level model of the fetch stage.
module tb_inst_fetcher;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;

  inst_fetcher_if fif ();

  inst_fetcher #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .fif    (fif.master)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;

  // Model: request outstanding / response to be dropped / word held for the decoder.
  bit          m_busy, m_stale, m_hold;
  logic [31:0] m_pc, m_req_addr, m_target, m_inst, m_iaddr;

  // Bench-side icache responder state for the random phase.
  bit ic_pend;
  int ic_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_stale = 0; m_hold = 0;
    m_pc = 32'h0; m_req_addr = 32'h0; m_target = 32'h0; m_inst = 32'h0; m_iaddr = 32'h0;
    ic_pend = 0; ic_lat = 0;
  endtask

  task automatic model_step(input bit wp, input logic [31:0] cpc, input bit iss,
                            input logic [31:0] npc, input bit resp, input logic [31:0] rinst);
    if (m_hold) begin
      if (wp)       begin m_hold = 0; m_pc = cpc; end
      else if (iss) begin m_hold = 0; m_pc = npc; end
    end else if (m_busy) begin
      if (resp) begin
        m_busy = 0;
        if (m_stale)  m_pc = wp ? cpc : m_target;
        else if (wp)  m_pc = cpc;
        else begin m_hold = 1; m_inst = rinst; m_iaddr = m_req_addr; end
        m_stale = 0;
      end else if (wp) begin
        m_stale = 1; m_target = cpc;
      end
    end else begin
      if (wp) m_pc = cpc;
      m_req_addr = m_pc;
      m_busy = 1;
      m_stale = 0;
    end
  endtask

  task automatic check_all();
    chk("ic_req_valid", {31'b0, fif.ic_req_valid}, {31'b0, m_busy});
    if (m_busy) chk("ic_req_addr", fif.ic_req_addr, m_req_addr);
    chk("start_decode", {31'b0, fif.start_decode}, {31'b0, m_hold});
    chk("inst", fif.inst, m_inst);
    chk("inst_addr", fif.inst_addr, m_iaddr);
  endtask

  // Called just after a falling edge; drives inputs, clocks once, checks at the next falling edge.
  task automatic step(input bit rdy, input bit wp, input logic [31:0] cpc, input bit iss,
                      input logic [31:0] npc, input bit resp, input logic [31:0] rinst);
    rdy_in = rdy;
    fif.wrong_predicted = wp; fif.correct_pc = cpc;
    fif.issue_signal = iss;   fif.next_pc = npc;
    fif.ic_resp_valid = resp; fif.ic_resp_inst = rinst;
    @(posedge clk_in);
    if (rdy) model_step(wp, cpc, iss, npc, resp, rinst);
    @(negedge clk_in);
    check_all();
  endtask

  task automatic idle();
    step(1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic apply_reset();
    rst_in = 1'b1;
    model_reset();
    repeat (2) @(negedge clk_in);
    check_all();
    rst_in = 1'b0;
  endtask

  initial begin
    fif.wrong_predicted = 0; fif.correct_pc = 0; fif.issue_signal = 0; fif.next_pc = 0;
    fif.ic_resp_valid = 0; fif.ic_resp_inst = 0;

    // 1: reset, first fetch at RESET_PC, one-cycle hit presented by the third edge.
    @(negedge clk_in);
    apply_reset();
    chk("t1_reset_req_valid", {31'b0, fif.ic_req_valid}, 32'h0);
    idle();
    chk("t1_req_addr", fif.ic_req_addr, 32'h0);
    step(1, 0, 0, 0, 0, 1, 32'h0050_0093);
    chk("t1_start_decode", {31'b0, fif.start_decode}, 32'h1);
    chk("t1_inst", fif.inst, 32'h0050_0093);

    // 2: decoder stalls for 10 cycles, then issues with next_pc=4.
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 32'h0000_0004, 1, 32'hFFFF_FFFF);
    chk("t2_inst_held", fif.inst, 32'h0050_0093);
    step(1, 0, 0, 1, 32'h0000_0004, 0, 0);
    idle();
    chk("t2_req_addr", fif.ic_req_addr, 32'h0000_0004);
    step(1, 0, 0, 0, 0, 1, 32'h1111_1111);

    // 3: redirect beats issue in the same cycle.
    step(1, 1, 32'h0000_0200, 1, 32'h0000_0100, 0, 0);
    idle();
    chk("t3_req_addr", fif.ic_req_addr, 32'h0000_0200);
    step(1, 0, 0, 0, 0, 1, 32'h2222_2222);
    step(1, 0, 0, 1, 32'h0000_0008, 0, 0);
    idle();
    chk("t4_wait_addr", fif.ic_req_addr, 32'h0000_0008);

    // 4: flush while waiting; late response must be dropped.
    step(1, 1, 32'h0000_0040, 0, 0, 0, 0);
    idle(); idle();
    step(1, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t4_no_decode", {31'b0, fif.start_decode}, 32'h0);
    idle();
    chk("t4_req_addr", fif.ic_req_addr, 32'h0000_0040);

    // 5: two flushes while discarding; latest target wins.
    step(1, 1, 32'h0000_0040, 0, 0, 0, 0);
    step(1, 1, 32'h0000_0080, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);
    idle();
    chk("t5_req_addr", fif.ic_req_addr, 32'h0000_0080);

    // 6: freeze during WAIT, then resume; then async reset mid-cycle while presenting.
    for (int i = 0; i < 5; i++)
      step(0, ($urandom % 2) == 1, $urandom, 1, $urandom, 1, $urandom);
    chk("t6_frozen_valid", {31'b0, fif.ic_req_valid}, 32'h1);
    chk("t6_frozen_addr", fif.ic_req_addr, 32'h0000_0080);
    step(1, 0, 0, 0, 0, 1, 32'h3333_3333);
    chk("t6_resume_inst", fif.inst, 32'h3333_3333);
    chk("t6_resume_iaddr", fif.inst_addr, 32'h0000_0080);
    #2 rst_in = 1'b1;
    #1;
    chk("t6_async_start_decode", {31'b0, fif.start_decode}, 32'h0);
    chk("t6_async_inst", fif.inst, 32'h0);
    chk("t6_async_inst_addr", fif.inst_addr, 32'h0);
    chk("t6_async_req_valid", {31'b0, fif.ic_req_valid}, 32'h0);
    @(negedge clk_in);
    apply_reset();

    // Random traffic with a bench-side icache of 0..3 extra wait cycles and spurious pulses.
    for (int c = 0; c < 3000; c++) begin
      bit          r_rdy, r_wp, r_iss, r_resp;
      logic [31:0] r_cpc, r_npc, r_rinst;
      r_rdy = ($urandom % 8) != 0;
      r_wp  = ($urandom % 12) == 0;
      r_iss = ($urandom % 3) == 0;
      r_cpc = $urandom; r_npc = $urandom; r_rinst = $urandom;
      if (fif.ic_req_valid && !ic_pend) begin
        ic_pend = 1;
        ic_lat  = int'($urandom % 4);
      end
      r_resp = ic_pend ? (ic_lat == 0) : (($urandom % 20) == 0);
      step(r_rdy, r_wp, r_cpc, r_iss, r_npc, r_resp, r_rinst);
      if (r_rdy && ic_pend) begin
        if (r_resp) ic_pend = 0;
        else        ic_lat--;
      end
      if (($urandom % 700) == 0) begin
        @(negedge clk_in);
        apply_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
Front-end fetch stage directly upstream of the decoder. It owns the architectural fetch PC and issues one-outstanding instruction requests to the icache. It presents the fetched word to the decoder through start_decode/inst/inst_addr and holds it until the decoder issues. It advances to the decoder-supplied next_pc and redirects to correct_pc on a ROB misprediction flush, dropping any stale in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-high
rdy_in  input  1  global ready; block freezes all state when low
wrong_predicted  input  1  ROB flush/redirect pulse
correct_pc  input  32  redirect target, valid with wrong_predicted
issue_signal  input  1  decoder accepted the held instruction
next_pc  input  32  decoder's next fetch address, valid with issue_signal
ic_req_valid  output  1  fetch request to icache
ic_req_addr  output  32  fetch address
ic_resp_valid  input  1  one-cycle pulse, response data valid
ic_resp_inst  input  32  fetched instruction word
start_decode  output  1  inst/inst_addr valid for decoder
inst  output  32  held instruction
inst_addr  output  32  address of held instruction

Behaviour:
- Reset (async, rst_in=1): state=FETCH, pc=RESET_PC, redirect_pc=0, inst=0, inst_addr=0, start_decode=0, ic_req_valid=0. The first request is raised on the first clk edge after reset deassert with rdy_in=1.
- rdy_in=0: no register changes and inputs are ignored. Outputs hold their values. The icache is frozen by the same rdy_in.
- States: FETCH, WAIT, DECODE, DISCARD. ic_req_valid=1 in WAIT and DISCARD only. start_decode=1 in DECODE only.
- ic_req_addr stays stable for the whole WAIT/DISCARD residency, from the first valid cycle until ic_resp_valid. There is one outstanding request maximum.
- FETCH: ic_req_addr<=pc and go to WAIT. This is a one-cycle bubble.
- WAIT, ic_resp_valid and no wrong_predicted: inst<=ic_resp_inst, inst_addr<=ic_req_addr, go to DECODE. start_decode rises the cycle after the response.
- WAIT, wrong_predicted and ic_resp_valid in the same cycle: drop the response, pc<=correct_pc, go to FETCH.
- WAIT, wrong_predicted without ic_resp_valid: redirect_pc<=correct_pc, go to DISCARD.
- DISCARD: on ic_resp_valid, drop the data, pc<=redirect_pc, go to FETCH. A further wrong_predicted while in DISCARD overwrites redirect_pc (latest wins). If it coincides with ic_resp_valid, the new correct_pc is used.
- DECODE, wrong_predicted: pc<=correct_pc, start_decode deasserts next cycle, go to FETCH. wrong_predicted has priority over issue_signal.
- DECODE, issue_signal (no wrong_predicted): pc<=next_pc, go to FETCH.
- DECODE with neither (decoder stalled, e.g. ROB/RS/LSB full or JALR dependency): hold inst, inst_addr and start_decode unchanged indefinitely.
- FETCH, wrong_predicted: pc<=correct_pc. The request uses the corrected pc.
- Best-case throughput is one instruction per 3 cycles (FETCH, WAIT with 1-cycle icache hit, DECODE).
- Spurious ic_resp_valid in FETCH/DECODE is ignored.
- The PC is not aligned or checked; addresses pass through unmodified (32-bit).
- Reset mid-WAIT: the outstanding request is abandoned. The icache is also reset by rst_in.

Test Plan:
1. Reset with RESET_PC=0, icache 1-cycle hit returning 0x00500093 → ic_req_addr=0. start_decode=1 with inst=0x00500093, inst_addr=0 by cycle 3 after reset release.
2. Held in DECODE, issue_signal=0 for 10 cycles, then issue_signal=1, next_pc=0x4 → inst/inst_addr constant for 10 cycles. Next ic_req_addr=0x4.
3. DECODE, issue_signal=1, next_pc=0x100 and wrong_predicted=1, correct_pc=0x200 in the same cycle → next ic_req_addr=0x200.
4. WAIT at addr 0x8, wrong_predicted with correct_pc=0x40, icache responds 3 cycles later with 0xDEADBEEF → start_decode stays 0 and 0xDEADBEEF is never presented. The next request is to 0x40.
5. In DISCARD, two wrong_predicted pulses with 0x40 then 0x80 before the response → the post-discard request goes to 0x80.
6. rdy_in=0 for 5 cycles during WAIT → state, pc and outputs are frozen. Operation resumes identically when rdy_in=1. Async rst_in asserted mid-cycle → outputs go to reset values immediately, without waiting for a clock edge.
